feat_readout: RTL and testbench

FEAT_READOUT -- requirements
Module: feat_readout

---
 rtl/feat_readout.sv | 140 ++++++++++++++
 tb/tb_feat_readout.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feat_readout.sv
// feat_readout: drains TOTAL_WORDS feature words from a BRAM port
// through a credit-controlled FIFO to a valid/ready output stream.
module feat_readout #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_W      = 10,
  parameter int TOTAL_WORDS = 32,
  parameter int RD_LAT      = 2,
  parameter int FF_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  feat_bram_enb,
  output logic [ADDR_W-1:0]     feat_bram_addrb,
  input  logic [DATA_WIDTH-1:0] feat_bram_dout,
  output logic                  feat_vld_o,
  input  logic                  feat_rdy_i,
  output logic [DATA_WIDTH-1:0] feat_data_o,
  output logic                  feat_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CW = ADDR_W + 1;
  localparam int PW = (FF_DEPTH > 1) ? $clog2(FF_DEPTH) : 1;
  localparam int OW = $clog2(FF_DEPTH + 4) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL_WORDS - 1);
  localparam logic [OW-1:0] DEPTH_C  = OW'(FF_DEPTH);
  localparam logic [PW-1:0] PTR_MAX  = PW'(FF_DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         iss_cnt_q, iss_cnt_d;
  logic [CW-1:0]         out_cnt_q, out_cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [RD_LAT-1:0]     vpipe_q, vpipe_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [DATA_WIDTH-1:0] mem_q [FF_DEPTH];

  logic [OW-1:0] in_flight;
  logic          issue;
  logic          push;
  logic          pop;
  logic          vld;
  logic          is_last;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  // Credit check, handshake terms and output decode.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      in_flight = in_flight + OW'(vpipe_q[i]);
    end
    issue   = (state_q == S_READ) && ((in_flight + occ_q) < DEPTH_C);
    push    = vpipe_q[RD_LAT-1];
    vld     = (occ_q != '0);
    pop     = vld && feat_rdy_i;
    is_last = (out_cnt_q == LAST_IDX);
    feat_bram_enb   = issue;
    feat_bram_addrb = issue ? iss_cnt_q[ADDR_W-1:0] : addr_q;
    feat_vld_o      = vld;
    feat_data_o     = vld ? mem_q[rd_ptr_q] : '0;
    feat_last_o     = vld && is_last;
    busy_o          = (state_q == S_READ) || (state_q == S_DRAIN);
    done_o          = (state_q == S_DONE);
  end

  // Next-state for FSM, counters, read-valid pipe and FIFO pointers.
  always_comb begin
    state_d   = state_q;
    iss_cnt_d = iss_cnt_q;
    out_cnt_d = out_cnt_q;
    addr_d    = issue ? iss_cnt_q[ADDR_W-1:0] : addr_q;
    vpipe_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop) occ_d = occ_q + 1'b1;
    if (pop && !push) occ_d = occ_q - 1'b1;
    if (issue) iss_cnt_d = iss_cnt_q + 1'b1;
    if (pop) out_cnt_d = out_cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_READ;
          iss_cnt_d = '0;
          out_cnt_d = '0;
        end
      end
      S_READ: begin
        if (issue && (iss_cnt_q == LAST_IDX)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && is_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      iss_cnt_q <= '0;
      out_cnt_q <= '0;
      addr_q    <= '0;
      vpipe_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      iss_cnt_q <= iss_cnt_d;
      out_cnt_q <= out_cnt_d;
      addr_q    <= addr_d;
      vpipe_q   <= vpipe_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
    end
  end

  // FIFO storage; contents are masked by occupancy so need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= feat_bram_dout;
  end

endmodule

// File: tb/tb_feat_readout.sv
// tb_feat_readout: scoreboard bench for feat_readout with a
// latency-accurate BRAM model and an occupancy model.
module tb_feat_readout;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rdy = 1'b0;
  logic        enb;
  logic [9:0]  addr;
  logic [15:0] dout;
  logic        vld;
  logic [15:0] data;
  logic        last;
  logic        busy;
  logic        done;

  logic        start1 = 1'b0;
  logic        rdy1 = 1'b1;
  logic        enb1;
  logic [9:0]  addr1;
  logic [15:0] dout1 = '0;
  logic        vld1;
  logic [15:0] data1;
  logic        last1;
  logic        busy1;
  logic        done1;

  always #5 clk = ~clk;

  feat_readout #(
    .DATA_WIDTH(16), .ADDR_W(10), .TOTAL_WORDS(32),
    .RD_LAT(2), .FF_DEPTH(4)
  ) u_dut (
    .clk(clk), .rst(rst), .start_i(start),
    .feat_bram_enb(enb), .feat_bram_addrb(addr),
    .feat_bram_dout(dout), .feat_vld_o(vld),
    .feat_rdy_i(rdy), .feat_data_o(data),
    .feat_last_o(last), .busy_o(busy), .done_o(done)
  );

  feat_readout #(
    .DATA_WIDTH(16), .ADDR_W(10), .TOTAL_WORDS(1),
    .RD_LAT(1), .FF_DEPTH(2)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start1),
    .feat_bram_enb(enb1), .feat_bram_addrb(addr1),
    .feat_bram_dout(dout1), .feat_vld_o(vld1),
    .feat_rdy_i(rdy1), .feat_data_o(data1),
    .feat_last_o(last1), .busy_o(busy1), .done_o(done1)
  );

  // BRAM models: mem[i] = i + 100.
  logic [15:0] b0 = '0, b1 = '0;
  always @(posedge clk) begin
    if (enb) b0 <= 16'(addr) + 16'd100;
    b1 <= b0;
  end
  assign dout = b1;

  always @(posedge clk) begin
    if (enb1) dout1 <= 16'(addr1) + 16'd100;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  // Occupancy model: returns land RD_LAT edges after enb.
  logic r0 = 1'b0, r1 = 1'b0;
  int   occ_m = 0;
  int   max_occ = 0;
  always @(posedge clk) begin
    if (rst) begin
      r0 <= 1'b0;
      r1 <= 1'b0;
      occ_m <= 0;
    end else begin
      r0 <= enb;
      r1 <= r0;
      occ_m <= occ_m + int'(r1) - int'(vld && rdy);
    end
  end
  always @(negedge clk) if (occ_m > max_occ) max_occ = occ_m;

  // Driver for downstream ready.
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: rdy = 1'b1;
      1: rdy = ($urandom_range(0, 99) < 30);
      default: rdy = 1'b0;
    endcase
  end

  logic [16:0] q[$];
  int start_cyc, first_vld, last_cyc, done_cyc;
  int xfer, enb_cnt, done_cnt, exp_addr;
  logic held_v;
  logic [16:0] held;

  task automatic clr_run();
    q.delete();
    first_vld = -1;
    last_cyc = -1;
    done_cyc = -1;
    xfer = 0;
    enb_cnt = 0;
    done_cnt = 0;
    exp_addr = 0;
    held_v = 1'b0;
    max_occ = 0;
  endtask

  // Monitor: address order, scoreboard pops, stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (enb) begin
        chk("addr", 32'(addr), 32'(exp_addr));
        exp_addr++;
        enb_cnt++;
      end
      if (vld && first_vld < 0) first_vld = cyc;
      if (held_v) begin
        chk("hold_vld", 32'(vld), 1);
        chk("hold_word", {15'd0, last, data}, {15'd0, held});
      end
      if (vld && rdy) begin
        if (q.size() == 0) chk("extra_word", {15'd0, last, data}, 0);
        else begin
          held = q.pop_front();
          chk("data", 32'(data), 32'(held[15:0]));
          chk("last", 32'(last), 32'(held[16]));
        end
        if (last) last_cyc = cyc;
        xfer++;
        held_v = 1'b0;
      end else if (vld) begin
        held_v = 1'b1;
        held = {last, data};
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic run_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    start_cyc = cyc;
    for (int i = 0; i < 32; i++) q.push_back({(i == 31), 16'(i + 100)});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("done_timeout", 32'(done_cnt > 0), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_enb"}, 32'(enb), 0);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_vld"}, 32'(vld), 0);
    chk({tag, "_last"}, 32'(last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_data"}, 32'(data), 0);
  endtask

  initial begin
    int t;
    int c0;
    logic found;
    clr_run();
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("rst");
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_start_busy", 32'(busy), 0);
    chk("rst_start_enb", 32'(enb), 0);

    // Full-rate run: latency and throughput.
    rdy_mode = 0;
    run_start();
    wait_done();
    chk("t1_first_vld", 32'(first_vld - start_cyc), 4);
    chk("t1_last_cyc", 32'(last_cyc - start_cyc), 35);
    chk("t1_done_cyc", 32'(done_cyc - start_cyc), 36);
    chk("t1_xfers", 32'(xfer), 32);
    chk("t1_enbs", 32'(enb_cnt), 32);
    chk("t1_q_empty", 32'(q.size()), 0);
    chk("t1_busy_off", 32'(busy), 0);

    // Random back-pressure.
    clr_run();
    rdy_mode = 1;
    run_start();
    wait_done();
    chk("t2_xfers", 32'(xfer), 32);
    chk("t2_q_empty", 32'(q.size()), 0);
    chk("t2_max_occ", 32'(max_occ <= 4), 1);

    // Long stall right after start.
    clr_run();
    rdy_mode = 2;
    run_start();
    repeat (19) @(posedge clk);
    #2;
    chk("t3_enbs", 32'(enb_cnt), 4);
    chk("t3_next_addr", 32'(exp_addr), 4);
    chk("t3_vld", 32'(vld), 1);
    chk("t3_data", 32'(data), 100);
    chk("t3_max_occ", 32'(max_occ), 4);
    rdy_mode = 0;
    wait_done();
    chk("t3_xfers", 32'(xfer), 32);
    chk("t3_q_empty", 32'(q.size()), 0);

    // Extra starts in READ and DRAIN are ignored.
    clr_run();
    rdy_mode = 1;
    run_start();
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (enb_cnt < 32 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("t4_in_drain", 32'(busy && done_cnt == 0), 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (40) @(posedge clk);
    chk("t4_done_cnt", 32'(done_cnt), 1);
    chk("t4_xfers", 32'(xfer), 32);
    chk("t4_enbs", 32'(enb_cnt), 32);

    // Reset mid-run, then a clean run.
    clr_run();
    rdy_mode = 0;
    run_start();
    t = 0;
    while (xfer < 10 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("t5_reach10", 32'(xfer >= 10), 1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("t5_rst");
    rst = 1'b0;
    clr_run();
    repeat (2) @(posedge clk);
    run_start();
    wait_done();
    chk("t5_xfers", 32'(xfer), 32);
    chk("t5_q_empty", 32'(q.size()), 0);

    // Single-word instance.
    @(posedge clk);
    #1;
    start1 = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vld1) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_found", 32'(found), 1);
    chk("t6_lat", 32'(cyc - c0), 3);
    chk("t6_data", 32'(data1), 100);
    chk("t6_last", 32'(last1), 1);
    @(negedge clk);
    chk("t6_done", 32'(done1), 1);
    chk("t6_vld_off", 32'(vld1), 0);
    @(negedge clk);
    chk("t6_done_once", 32'(done1), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
